// File: rtl/prog_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : prog_mem                                                      |
// | Brief    : Writable instruction memory for the jacaranda-8 core, with a  |
// |            combinational fetch port and a byte-stream load port.         |
// |            Optional trailing checksum: define PROG_MEM_CHECKSUM_EN.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module prog_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] instr,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic [ADDR_WIDTH-1:0] load_len,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  load_busy,
  output logic                  cpu_stall,
  output logic                  load_done
`ifdef PROG_MEM_CHECKSUM_EN
  ,
  output logic                  load_err
`endif
);

  localparam int c_depth = 2 ** ADDR_WIDTH;

`ifdef PROG_MEM_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1
  } state_t;
`endif

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_start;
  logic                    w_write;
  logic                    w_last;
  logic                    w_finish;
  logic [ADDR_WIDTH-1:0]   r_wptr;
  logic [ADDR_WIDTH-1:0]   r_remaining;
  logic                    r_done;

  // Contents are not touched by reset, so they survive rst_n.
  logic [DATA_WIDTH-1:0]   r_mem [c_depth] = '{default: '0};

  assign w_accept = load_valid & w_ready;
  assign w_start  = (r_state == ST_IDLE) & load_start;
  assign w_write  = (r_state == ST_LOAD) & w_accept;
  assign w_last   = w_write & (r_remaining == '0);

`ifdef PROG_MEM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   r_sum;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   w_chk;

  assign w_chk    = r_sum + load_data;
  assign w_finish = (r_state == ST_CHECK) & w_accept;
  assign load_err = r_err;
`else
  assign w_finish = w_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_start) begin
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_ready = 1'b1;
        if (w_last) begin
`ifdef PROG_MEM_CHECKSUM_EN
          w_next = ST_CHECK;
`else
          w_next = ST_IDLE;
`endif
        end
      end
`ifdef PROG_MEM_CHECKSUM_EN
      ST_CHECK: begin
        w_ready = 1'b1;
        if (w_accept) begin
          w_next = ST_IDLE;
        end
      end
`endif
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_start) begin
        r_wptr      <= load_base;
        r_remaining <= load_len;
      end else if (w_write) begin
        // Pointer wraps naturally at the top of the address space.
        r_wptr <= r_wptr + ADDR_WIDTH'(1);
        if (r_remaining != '0) begin
          r_remaining <= r_remaining - ADDR_WIDTH'(1);
        end
      end
    end
  end

`ifdef PROG_MEM_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_sum <= '0;
        r_err <= 1'b0;
      end else if (w_write) begin
        r_sum <= w_chk;
      end else if (w_finish) begin
        // Sticky until the next accepted load_start.
        r_err <= r_err | (w_chk != '0);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wptr] <= load_data;
    end
  end

  assign instr      = r_mem[addr];
  assign load_ready = w_ready;
  assign load_busy  = (r_state != ST_IDLE);
  assign cpu_stall  = load_busy;
  assign load_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_prog_mem                                                   |
// | Brief    : Directed self-checking bench for prog_mem with a read-back    |
// |            scoreboard; checksum steps built with PROG_MEM_CHECKSUM_EN.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_prog_mem;

  logic       clk;
  logic       rst_n;
  logic [7:0] addr;
  logic [7:0] instr;
  logic       load_start;
  logic [7:0] load_base;
  logic [7:0] load_len;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic       load_busy;
  logic       cpu_stall;
  logic       load_done;
`ifdef PROG_MEM_CHECKSUM_EN
  logic       load_err;
`endif

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t       q[$];
  logic [7:0] model [256];
  logic [7:0] stim  [16];
  int         checks;
  int         errors;

  prog_mem #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .instr      (instr),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .cpu_stall  (cpu_stall),
    .load_done  (load_done)
`ifdef PROG_MEM_CHECKSUM_EN
    ,
    .load_err   (load_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one load from stim[]; bench model and scoreboard track accepted bytes.
  task automatic do_load(input logic [7:0] base, input logic [7:0] len,
                         input bit bubbles, input bit mid);
    logic [7:0] wp;
    int n;
    int i;
    int cyc;
    wp = base;
    n  = int'(len) + 1;
`ifdef PROG_MEM_CHECKSUM_EN
    n  = n + 1;
`endif
    load_base  = base;
    load_len   = len;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    load_base  = 8'h5A;
    load_len   = 8'h07;
    chk("busy_rise", {31'd0, load_busy}, 32'd1);
    chk("stall_rise", {31'd0, cpu_stall}, 32'd1);
    i = 0;
    cyc = 0;
    while (i < n) begin
      load_valid = bubbles ? ((cyc % 2) == 0) : 1'b1;
      load_data  = stim[i];
      if (mid && cyc == 1) begin
        load_start = 1'b1;
        load_base  = 8'h80;
        load_len   = 8'h00;
      end
      chk("ready_load", {31'd0, load_ready}, 32'd1);
      @(posedge clk); #1;
      load_start = 1'b0;
      if (load_valid) begin
        if (i <= int'(len)) begin
          model[wp] = stim[i];
          q.push_back({wp, stim[i]});
          wp = wp + 8'd1;
        end else begin
          q.push_back({wp, model[wp]});
        end
        i++;
      end
      cyc++;
      if (i < n) chk("done_early", {31'd0, load_done}, 32'd0);
    end
    load_valid = 1'b0;
    chk("done_pulse", {31'd0, load_done}, 32'd1);
    chk("busy_fall", {31'd0, load_busy}, 32'd0);
    chk("ready_idle", {31'd0, load_ready}, 32'd0);
    @(posedge clk); #1;
    chk("done_single", {31'd0, load_done}, 32'd0);
  endtask

  task automatic verify();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      addr = e.a;
      #1;
      chk($sformatf("mem[%02h]", e.a), {24'd0, instr}, {24'd0, e.d});
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    addr       = 8'h00;
    load_start = 1'b0;
    load_base  = 8'h00;
    load_len   = 8'h00;
    load_data  = 8'h00;
    load_valid = 1'b0;
    for (int k = 0; k < 256; k++) model[k] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, load_busy}, 32'd0);
    chk("rst_ready", {31'd0, load_ready}, 32'd0);
    chk("rst_done", {31'd0, load_done}, 32'd0);
`ifdef PROG_MEM_CHECKSUM_EN
    chk("rst_err", {31'd0, load_err}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_stall", {31'd0, cpu_stall}, 32'd0);
    chk("idle_ready", {31'd0, load_ready}, 32'd0);
    for (int k = 0; k < 4; k++) q.push_back({8'(k), 8'h00});
    verify();

    // Straight load, valid held high.
    stim[0] = 8'hC0; stim[1] = 8'hD1; stim[2] = 8'h03; stim[3] = 8'h2C;
    do_load(8'h00, 8'd2, 1'b0, 1'b0);
    verify();

    // Wrap through 0xFF -> 0x00 with bubbles.
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44;
    stim[4] = 8'h56;
    do_load(8'hFE, 8'd3, 1'b1, 1'b0);
    verify();

    // load_start re-pulsed with a different base mid-load is ignored.
    stim[0] = 8'hA1; stim[1] = 8'hA2; stim[2] = 8'hA3; stim[3] = 8'h18;
    do_load(8'h10, 8'd2, 1'b0, 1'b1);
    q.push_back({8'h80, model[8'h80]});
    verify();

    // Reset dropped after the first of three bytes.
    load_base  = 8'h40;
    load_len   = 8'd2;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hAA;
    @(posedge clk); #1;
    model[8'h40] = 8'hAA;
    load_data  = 8'hBB;
    #2;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, load_busy}, 32'd0);
    chk("rstmid_ready", {31'd0, load_ready}, 32'd0);
    chk("rstmid_stall", {31'd0, cpu_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rstmid_nodone", {31'd0, load_done}, 32'd0);
    end
    q.push_back({8'h40, 8'hAA});
    q.push_back({8'h41, model[8'h41]});
    verify();

`ifdef PROG_MEM_CHECKSUM_EN
    stim[0] = 8'h10; stim[1] = 8'h20; stim[2] = 8'hD0;
    do_load(8'h20, 8'd1, 1'b0, 1'b0);
    chk("csum_ok", {31'd0, load_err}, 32'd0);
    verify();

    stim[0] = 8'h10; stim[1] = 8'h20; stim[2] = 8'hD1;
    do_load(8'h30, 8'd1, 1'b1, 1'b0);
    chk("csum_bad", {31'd0, load_err}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("csum_sticky", {31'd0, load_err}, 32'd1);
    verify();

    stim[0] = 8'h07; stim[1] = 8'hF9;
    do_load(8'h50, 8'd0, 1'b0, 1'b0);
    chk("csum_clear", {31'd0, load_err}, 32'd0);
    verify();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_mem.md
# prog_mem

Parametrised, writable instruction memory for the jacaranda-8 core. It keeps the combinational fetch port the CPU already uses, so `instr` follows `addr` in the same cycle. It adds a byte-stream program-load port with a valid/ready handshake, a load state machine, and a CPU stall output. Programs can therefore be loaded at run time, for example from a UART receiver, instead of being fixed at elaboration.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: fetch/load address width; depth is 2**ADDR_WIDTH words.
- `DATA_WIDTH`, 8: instruction word width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `addr`  in  ADDR_WIDTH  fetch address from the PC.
- `instr`  out  DATA_WIDTH  `mem[addr]`, combinational.
- `load_start`  in  1  request a load; sampled only in IDLE.
- `load_base`  in  ADDR_WIDTH  first write address; captured on an accepted `load_start`.
- `load_len`  in  ADDR_WIDTH  program bytes minus one; captured on an accepted `load_start`.
- `load_data`  in  DATA_WIDTH  stream byte.
- `load_valid`  in  1  `load_data` is valid.
- `load_ready`  out  1  block accepts a byte this cycle.
- `load_busy`  out  1  state is not IDLE.
- `cpu_stall`  out  1  hold the CPU; equal to `load_busy`.
- `load_done`  out  1  one-cycle pulse when a load finishes.
- `load_err`  out  1  checksum mismatch; sticky. Present only with `PROG_MEM_CHECKSUM_EN`.

## Operation
- Memory: 2**ADDR_WIDTH × DATA_WIDTH array.
  - Initialised to all zeros for simulation.
  - Not cleared by reset; contents survive `rst_n`.
- States: IDLE, LOAD, CHECK (CHECK exists only with the macro).
- IDLE:
  - `load_ready`=0.
  - `load_start`=1 captures `load_base` into `wptr` and `load_len` into `remaining`, then moves to LOAD.
- LOAD:
  - `load_ready`=1.
  - On `load_valid & load_ready`: write `mem[wptr] <= load_data`, then `wptr <= wptr+1`.
  - `wptr` wraps modulo 2**ADDR_WIDTH; a load can start at 0xF0 and continue through 0x00.
  - When the accepted byte is taken with `remaining`==0: go to CHECK (macro on) or IDLE (macro off). Otherwise `remaining <= remaining-1`.
- CHECK:
  - `load_ready`=1. The next accepted byte is the checksum and is not written.
  - Set `load_err` if `sum + byte` is not 0 mod 2**DATA_WIDTH, then go to IDLE.
- `load_start` is ignored outside IDLE.
- A `load_valid` byte is never consumed in IDLE.
- Maximum load is 2**ADDR_WIDTH bytes (`load_len` all ones). Every location is written exactly once, and the last write lands at `load_base-1`.
- Fetch and load are independent:
  - `instr` reads the pre-edge content during a same-cycle write to `addr`.
  - The CPU is expected to respect `cpu_stall`; the block does not gate `instr`.

## Timing
- Reset values: state IDLE, `load_ready`=0, `load_busy`=0, `cpu_stall`=0, `load_done`=0, `load_err`=0, `wptr`=0, `remaining`=0, checksum accumulator 0.
- `instr` has zero latency from `addr` and from the clock edge that writes the addressed word.
- `load_busy`/`cpu_stall` rise in the cycle after `load_start` is sampled.
- Throughput is one byte per cycle while `load_valid` stays high. The source may insert bubbles arbitrarily.
- `load_done` pulses high for exactly one cycle, in the cycle after the final byte (data byte, or checksum with the macro) is accepted. `load_busy` is 0 in that same cycle.
- A new `load_start` is accepted in the `load_done` cycle.
- `rst_n` asserted mid-load:
  - State returns immediately to IDLE.
  - Bytes already written stay written.
  - No `load_done` pulse is produced.

## Configuration
- `PROG_MEM_CHECKSUM_EN` defined:
  - CHECK state, `load_err` port and an 8-bit (DATA_WIDTH) running sum are compiled in.
  - The sum is cleared on `load_start` and accumulates each written byte.
  - `load_err` is cleared on an accepted `load_start`.
  - A load takes `load_len+2` accepted bytes.
- Undefined:
  - No CHECK state and no `load_err` port.
  - A load takes `load_len+1` bytes.
  - `load_done` follows the last data byte.

## Test plan
- Reset, then fetch: drive `addr`=0x00..0x03 → `instr`=0x00 for each; `cpu_stall`=0, `load_ready`=0.
- Load `load_base`=0x00, `load_len`=2, bytes 0xC0, 0xD1, 0x03, with `load_valid` held high → `load_ready` high for 3 cycles, `load_done` pulses in the cycle after 0x03 is accepted, and `addr`=0x02 reads 0x03.
- Wrap and bubbles: `load_base`=0xFE, `load_len`=3, bytes 0x11/0x22/0x33/0x44 with `load_valid` toggling → `mem[0xFE]`=0x11, `mem[0xFF]`=0x22, `mem[0x00]`=0x33, `mem[0x01]`=0x44.
- Mid-load events: `load_start` re-pulsed and `load_base` changed mid-load → ignored. `rst_n` dropped after 1 of 3 bytes → immediate IDLE, first byte retained, no `load_done`.
- Macro on:
  - Bytes 0x10, 0x20, checksum 0xD0 → `load_err`=0.
  - Checksum 0xD1 → `load_err`=1, held until the next `load_start`.
  - The checksum byte is not written to memory.
